// File: rtl/demux2_pkg.sv
// demux2_pkg: shared constants for the 1-to-2 stream demultiplexer.
package demux2_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
  localparam int STAT_W = 16;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with separate occupancy count and async reset.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CW-1:0]         count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;
  assign count_d = count_q + CW'(push) - CW'(pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(push);
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      count_q  <= count_d;
    end
  // Storage is deliberately left out of reset; the count gates visibility.
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= data_i;
endmodule

// File: rtl/demux2_stream.sv
// demux2_stream: registered 1-to-2 stream demux into two independent FIFOs.
// Define DEMUX2_STREAM_STATS_EN to add saturating accept/stall counters.
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic [DATA_WIDTH-1:0]        i_DataIn,
  input  logic                         i_Select,
  input  logic                         i_Valid,
  output logic                         o_Ready,
  output logic [DATA_WIDTH-1:0]        o_DataOutA,
  output logic                         o_ValidA,
  input  logic                         i_ReadyA,
  output logic [DATA_WIDTH-1:0]        o_DataOutB,
  output logic                         o_ValidB,
  input  logic                         i_ReadyB,
`ifdef DEMUX2_STREAM_STATS_EN
  output logic [STAT_W-1:0]            o_AcceptCntA,
  output logic [STAT_W-1:0]            o_AcceptCntB,
  output logic [STAT_W-1:0]            o_StallCnt,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   o_CountA,
  output logic [$clog2(DEPTH+1)-1:0]   o_CountB
);
  logic [DATA_WIDTH-1:0] head_a, head_b;
  logic full_a, full_b, empty_a, empty_b, push_a, push_b;
  // Ready looks only at the selected channel's fullness, never at consumer ready.
  assign o_Ready    = i_Select == SEL_B ? !full_b : !full_a;
  assign push_a     = i_Valid && o_Ready && i_Select == SEL_A;
  assign push_b     = i_Valid && o_Ready && i_Select == SEL_B;
  assign o_ValidA   = !empty_a;
  assign o_ValidB   = !empty_b;
  assign o_DataOutA = o_ValidA ? head_a : '0;
  assign o_DataOutB = o_ValidB ? head_b : '0;
  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk(i_Clk), .rst(i_Rst), .push_i(push_a), .pop_i(o_ValidA && i_ReadyA),
    .data_i(i_DataIn), .data_o(head_a), .full_o(full_a), .empty_o(empty_a),
    .count_o(o_CountA)
  );
  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk(i_Clk), .rst(i_Rst), .push_i(push_b), .pop_i(o_ValidB && i_ReadyB),
    .data_i(i_DataIn), .data_o(head_b), .full_o(full_b), .empty_o(empty_b),
    .count_o(o_CountB)
  );
`ifdef DEMUX2_STREAM_STATS_EN
  logic [STAT_W-1:0] acc_a_q, acc_b_q, stall_q;
  assign o_AcceptCntA = acc_a_q;
  assign o_AcceptCntB = acc_b_q;
  assign o_StallCnt   = stall_q;
  always_ff @(posedge i_Clk or posedge i_Rst)
    if (i_Rst) begin
      acc_a_q <= '0;
      acc_b_q <= '0;
      stall_q <= '0;
    end else begin
      if (push_a && acc_a_q != '1) acc_a_q <= acc_a_q + 1'b1;
      if (push_b && acc_b_q != '1) acc_b_q <= acc_b_q + 1'b1;
      if (i_Valid && !o_Ready && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
`endif
  always @(posedge i_Clk)
    if (!i_Rst && i_Valid) assert (!$isunknown(i_Select));
endmodule

// File: doc/demux2_stream.md
Name: demux2_stream

Overview:
- Registered 1-to-2 stream demultiplexer, the write-side counterpart of the datapath's 2:1 select mux.
- Takes one valid/ready input stream plus a per-beat select bit.
- Steers each beat into one of two independent output FIFOs (channel A for select 0, channel B for select 1).
- Used where one producer, such as the writeback/LSU path, feeds two consumers that may stall independently.

Parameters:
- DATA_WIDTH, 32, width of every data beat.
- DEPTH, 2, entries per output FIFO; must be a power of 2 and at least 2.

Ports:
- i_Clk  input  1  single clock; all state updates on its rising edge.
- i_Rst  input  1  asynchronous, active-high reset.
- i_DataIn  input  DATA_WIDTH  input beat.
- i_Select  input  1  0 routes the beat to channel A, 1 routes it to channel B.
- i_Valid  input  1  input beat valid.
- o_Ready  output  1  input beat will be accepted this cycle.
- o_DataOutA  output  DATA_WIDTH  head entry of FIFO A.
- o_ValidA  output  1  FIFO A non-empty.
- i_ReadyA  input  1  consumer A pops the head this cycle.
- o_DataOutB  output  DATA_WIDTH  head entry of FIFO B.
- o_ValidB  output  1  FIFO B non-empty.
- i_ReadyB  input  1  consumer B pops the head this cycle.
- o_CountA  output  $clog2(DEPTH+1)  occupancy of FIFO A.
- o_CountB  output  $clog2(DEPTH+1)  occupancy of FIFO B.

Behaviour:
- Reset (asserted asynchronously, released synchronously to i_Clk):
  - Pointers and counts go to 0.
  - o_ValidA and o_ValidB go to 0.
  - o_DataOutA and o_DataOutB go to 32'b0.
  - The FIFO storage array is not required to be cleared.
- Reset mid-operation discards all buffered beats; no partial pop is visible.
- o_Ready = !full(channel selected by i_Select).
  - Combinational from i_Select and the occupancy counts only.
  - Never depends on i_ReadyA or i_ReadyB, so there is no combinational path from consumer ready to producer ready.
- Accept happens when i_Valid && o_Ready. The beat is written at the tail of the selected FIFO at the clock edge.
- Push latency is 1 cycle: a beat accepted at edge N appears on o_DataOut*/o_Valid* after edge N, provided the FIFO was empty.
- Pop on channel X happens when o_ValidX && i_ReadyX. The head advances at the edge.
- i_ReadyX while o_ValidX is 0 has no effect.
- Push and pop on the same channel in the same cycle:
  - Count is unchanged.
  - Allowed only when the FIFO is not full, since o_Ready ignores the pop.
- Full: the selected channel blocks input only. The other channel keeps accepting if i_Select changes.
- o_DataOutX = head entry when o_ValidX is 1, otherwise 0. This is the explicit default, mirroring the mux default arm.
- Pointers are log2(DEPTH) bits and wrap naturally; count is held separately (or derived from an extra pointer bit).
- Ordering is preserved within each channel. There is no ordering relation between A and B.
- X on i_Select while i_Valid is 1 is illegal; an assertion flags it in simulation.

Optional Feature:
- DEMUX2_STREAM_STATS_EN, when defined, adds three outputs:
  - o_AcceptCntA and o_AcceptCntB, 16-bit beats accepted per channel.
  - o_StallCnt, 16-bit count of cycles with i_Valid && !o_Ready.
- All three counters saturate at 16'hFFFF, never wrap, and reset to 0.
- When the macro is undefined, these ports and their logic do not exist and the block behaves identically otherwise.

Decomposition:
- demux2_pkg holds:
  - DEFAULT_DATA_WIDTH = 32.
  - Select encodings SEL_A = 1'b0 and SEL_B = 1'b1.
  - Stats counter width STAT_W = 16.
- One sub-module is natural: sync_fifo (DATA_WIDTH, DEPTH), with push, pop, data in/out, full, empty and count. It is instantiated twice.
- demux2_stream holds only steering, o_Ready generation, the output zero-default and the optional stats.

Test Plan:
- Reset check: assert i_Rst mid-stream with A holding 2 beats → o_ValidA=0, o_CountA=0, o_DataOutA=0 immediately, without waiting for a clock edge; o_Ready=1 after release.
- Steering and latency: push 32'hAAAA0001 (sel 0), then 32'hBBBB0001 (sel 1), with both readies low → next cycle A head=AAAA0001, B head=BBBB0001, counts 1/1.
- Full/backpressure, DEPTH=2:
  - Push 3 beats to A with i_ReadyA=0 → third beat sees o_Ready=0 and CountA=2.
  - Switching i_Select to 1 gives o_Ready=1 and the beat lands in B.
- Simultaneous push/pop: A holds 1 beat; push 32'h2 to A while i_ReadyA=1 → CountA stays 1, head becomes 32'h2 after the edge.
- Wrap-around: stream 10 sequential values through A with random i_ReadyA → output order 0..9 exact, no loss, and B stays empty throughout.
- With DEMUX2_STREAM_STATS_EN defined: hold A full and i_Valid=1 for 5 cycles with sel 0 → o_StallCnt=5. Drive 70000 accepts → o_AcceptCntA saturates at 16'hFFFF.
